// File: rtl/comp_pkg.sv
// Shared definitions for the compression packetizer: mode codes (common with the
// decompression side), header field positions, FSM states and a popcount helper.
package comp_pkg;

   localparam logic [1:0] MODE_BPC = 2'b00;
   localparam logic [1:0] MODE_ZRL = 2'b01;
   localparam logic [1:0] MODE_SR  = 2'b10;

   localparam int HDR_MODE_HI = 63;
   localparam int HDR_MODE_LO = 62;
   localparam int HDR_CNT_HI  = 39;
   localparam int HDR_CNT_LO  = 32;
   localparam int HDR_MAP_HI  = 31;
   localparam int HDR_MAP_LO  = 0;

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_HDR  = 2'd1,
      S_PAY  = 2'd2
   } state_t;

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] c;
      c = 6'd0;
      for (int i = 0; i < 32; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/comp_ffs.sv
// 32-bit find-first-set (lowest set bit wins); used only when COMP_ZRL_EN is defined
// to pick the next nonzero word of a ZRL payload.
module comp_ffs (
   input  logic [31:0] vec,
   output logic [4:0]  idx,
   output logic        found
);

   // Scan from the top so the lowest set bit is the last one to overwrite idx.
   always_comb begin
      idx   = 5'd0;
      found = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         idx   = vec[i] ? 5'(i) : idx;
         found = found | vec[i];
      end
   end

endmodule

// File: rtl/comp_packetizer.sv
// Buffers one uncompressed block and emits it as a ZRL or SR packet with a mode header.
// Optional feature macro: COMP_ZRL_EN (ZRL selection; without it every block is SR).
module comp_packetizer
   import comp_pkg::*;
#(
   parameter int BLK_WORDS     = 16,
   parameter int ZRL_MIN_ZEROS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] data_i,
   input  logic        valid_i,
   input  logic        sop_i,
   input  logic        eop_i,
   output logic        ready_o,
   output logic [63:0] data_o,
   output logic        valid_o,
   output logic        sop_o,
   output logic        eop_o,
   input  logic        ready_i,
   output logic        err_o
);

   localparam int IW    = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
   localparam int DEPTH = 1 << IW;

   state_t      state;
   logic [5:0]  n;
   logic [1:0]  mode;
   logic [4:0]  ptr;
   logic [4:0]  last;
   logic [63:0] buf_mem [DEPTH];

   logic        accept;
   logic        write;
   logic        close;
   logic [4:0]  beat_idx;
   logic [5:0]  n_next;
   logic [1:0]  sel_mode;
   logic [31:0] bitmap;
   logic        hdr_eop;
   logic [63:0] hdr;
   logic [4:0]  pay_idx;
   logic        pay_last;

`ifdef COMP_ZRL_EN
   logic [31:0] nz;
   logic [31:0] nz_next;
   logic [31:0] rem;
   logic [31:0] rem_nxt;
   logic [5:0]  zeros;
   logic [4:0]  ffs_idx;
   logic        ffs_found;

   comp_ffs u_ffs (
      .vec   (rem),
      .idx   (ffs_idx),
      .found (ffs_found)
   );
`endif

   assign accept   = valid_i & ready_o;
   assign write    = accept & (sop_i | (n != 6'd0));
   assign beat_idx = sop_i ? 5'd0 : n[4:0];
   assign n_next   = {1'b0, beat_idx} + 6'd1;
   assign close    = write & (eop_i | (n_next == 6'(BLK_WORDS)));

   // Mode decision and header word for the block that closes on this beat.
   always_comb begin
      sel_mode = MODE_SR;
      bitmap   = 32'd0;
`ifdef COMP_ZRL_EN
      nz_next = (sop_i ? 32'd0 : nz) | ({31'd0, (data_i != 64'd0)} << beat_idx);
      zeros   = n_next - popcount32(nz_next);
      if ({26'd0, zeros} >= 32'(ZRL_MIN_ZEROS)) begin
         sel_mode = MODE_ZRL;
         bitmap   = nz_next;
      end else begin
         sel_mode = MODE_SR;
         bitmap   = 32'd0;
      end
`endif
      hdr_eop = (sel_mode == MODE_ZRL) && (bitmap == 32'd0);
      hdr = 64'd0;
      hdr[HDR_MODE_HI:HDR_MODE_LO] = sel_mode;
      hdr[HDR_CNT_HI:HDR_CNT_LO]   = {2'b00, n_next};
      hdr[HDR_MAP_HI:HDR_MAP_LO]   = bitmap;
   end

   // Next payload index: sequential for SR, lowest remaining nonzero word for ZRL.
   always_comb begin
      pay_idx  = ptr;
      pay_last = (ptr == last);
`ifdef COMP_ZRL_EN
      rem_nxt = rem;
      if ((mode == MODE_ZRL) && ffs_found) begin
         pay_idx  = ffs_idx;
         rem_nxt  = rem & ~(32'd1 << ffs_idx);
         pay_last = (rem_nxt == 32'd0);
      end else begin
         rem_nxt = rem;
      end
`endif
   end

   // Block buffer; contents need no reset since nothing is read before it is written.
   always_ff @(posedge clk) begin
      if (write) begin
         buf_mem[beat_idx[IW-1:0]] <= data_i;
      end
   end

   // Fill / header / payload sequencing with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FILL;
         n       <= 6'd0;
         mode    <= MODE_SR;
         ptr     <= 5'd0;
         last    <= 5'd0;
         ready_o <= 1'b0;
         valid_o <= 1'b0;
         sop_o   <= 1'b0;
         eop_o   <= 1'b0;
         data_o  <= 64'd0;
         err_o   <= 1'b0;
`ifdef COMP_ZRL_EN
         nz      <= 32'd0;
         rem     <= 32'd0;
`endif
      end else begin
         case (state)
            S_FILL: begin
               ready_o <= 1'b1;
               if (accept && !write) begin
                  err_o <= 1'b1;
               end
               if (write) begin
                  n <= n_next;
`ifdef COMP_ZRL_EN
                  nz <= nz_next;
`endif
                  if (sop_i && (n != 6'd0)) begin
                     err_o <= 1'b1;
                  end
               end
               if (close) begin
                  if (!eop_i) begin
                     err_o <= 1'b1;
                  end
                  state   <= S_HDR;
                  ready_o <= 1'b0;
                  valid_o <= 1'b1;
                  sop_o   <= 1'b1;
                  eop_o   <= hdr_eop;
                  data_o  <= hdr;
                  mode    <= sel_mode;
                  ptr     <= 5'd0;
                  last    <= n_next[4:0] - 5'd1;
`ifdef COMP_ZRL_EN
                  rem     <= bitmap;
`endif
               end
            end
            S_HDR, S_PAY: begin
               if (valid_o && ready_i) begin
                  if (eop_o) begin
                     state   <= S_FILL;
                     n       <= 6'd0;
                     ready_o <= 1'b1;
                     valid_o <= 1'b0;
                     sop_o   <= 1'b0;
                     eop_o   <= 1'b0;
                     data_o  <= 64'd0;
                  end else begin
                     state  <= S_PAY;
                     sop_o  <= 1'b0;
                     eop_o  <= pay_last;
                     data_o <= buf_mem[pay_idx[IW-1:0]];
                     ptr    <= ptr + 5'd1;
`ifdef COMP_ZRL_EN
                     rem    <= rem_nxt;
`endif
                  end
               end
            end
            default: begin
               state   <= S_FILL;
               n       <= 6'd0;
               ready_o <= 1'b0;
               valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/comp_packetizer.md
# comp_packetizer

Transmit-side block counterpart of the decompression dispatcher. It accepts one uncompressed block of up to `BLK_WORDS` 64-bit words on a sop/eop stream and buffers it. It then chooses an encoding (ZRL or SR) and emits a packet whose first word carries the mode in bits [63:62], which is exactly what the decoder dispatches on. Mode code 2'b00 (BPC) is reserved for the separate BPC engine and is never produced here.

## Interface
Parameters:
- `BLK_WORDS`, default 16: maximum words per block, legal range 1..32.
- `ZRL_MIN_ZEROS`, default 1: minimum count of all-zero words in a block required to select ZRL.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_i`  in  64: uncompressed input word.
- `valid_i`  in  1: input word valid.
- `sop_i`  in  1: first word of block.
- `eop_i`  in  1: last word of block.
- `ready_o`  out  1: block accepts an input word.
- `data_o`  out  64: packet word.
- `valid_o`  out  1: output word valid.
- `sop_o`  out  1: header beat.
- `eop_o`  out  1: final packet beat.
- `ready_i`  in  1: downstream accepts an output word.
- `err_o`  out  1: sticky protocol-error flag.

## Operation
- States: FILL, HDR, PAY.
- **FILL** (`ready_o`=1):
  - Each `valid_i`&`ready_o` beat writes `buf[n]` and sets `nz[n]` = (`data_i`!=0), then increments `n`.
  - The first beat must carry `sop_i`. A beat without it is dropped and sets `err_o`.
  - `sop_i` on a later beat discards the partial block, restarts at n=0 with this word, and sets `err_o`.
  - A beat with `eop_i`, or the beat that makes n==`BLK_WORDS`, closes the block and moves to HDR. Reaching `BLK_WORDS` without `eop_i` also sets `err_o`.
  - Any further words before the next `sop_i` are dropped and set `err_o`.
- **Mode select** (at close): ZRL if (n − popcount(nz)) ≥ `ZRL_MIN_ZEROS`, else SR.
- **Header word layout**:
  - [63:62] = mode: ZRL = 2'b01, SR = 2'b10.
  - [61:40] = 0.
  - [39:32] = n.
  - [31:0] = ZRL: `nz` bitmap (bit i = word i nonzero, bits ≥ n zero); SR: 0.
- **HDR**: drive the header with `sop_o`=1. `eop_o`=1 as well if there is no payload (ZRL with bitmap 0). On acceptance go to PAY, or to FILL if the header was the last beat.
- **PAY**:
  - SR emits `buf[0..n-1]` in order.
  - ZRL emits only the `buf[i]` with `nz[i]`=1, in ascending i. The next index comes from find-first-set over the remaining mask, giving one word per cycle with no bubbles.
  - `eop_o` marks the last payload word. Its acceptance returns the block to FILL.
- Block sizes: n=1 is legal. n is 6 bits wide; all index arithmetic is 5 bits.

## Timing
- Reset values:
  - `valid_o`, `sop_o`, `eop_o`, `err_o` = 0; `data_o` = 0.
  - `ready_o` = 0 while `rst_n` is low, and 1 in the first cycle after release.
  - State = FILL, n = 0.
- Header latency: `valid_o` rises the cycle after the closing input beat is accepted.
- Throughput: one output beat per cycle while `ready_i`=1.
- `ready_o` is 0 from the cycle after the close through the cycle the final output beat is accepted. The next input beat can be accepted the following cycle.
- Output hold: while `valid_o`&!`ready_i`, `data_o`, `sop_o` and `eop_o` are held stable. No beat is lost or duplicated.
- `valid_i` with `ready_o`=0 is ignored; the upstream holds the word.
- Reset mid-packet: the block is abandoned immediately; outputs return to their reset values.

## Configuration
- `COMP_ZRL_EN` defined: mode select works as described above.
- `COMP_ZRL_EN` undefined:
  - Every block is emitted as SR.
  - Header bits [31:0] = 0.
  - The find-first-set logic and `ZRL_MIN_ZEROS` are unused.
  - Fill and protocol-error behaviour are unchanged.

## Structure
- Package `comp_pkg` holds:
  - Mode constants `MODE_BPC`=2'b00, `MODE_ZRL`=2'b01, `MODE_SR`=2'b10, shared with the decompression side.
  - Header field positions (mode [63:62], count [39:32], bitmap [31:0]).
  - The state enum.
- Sub-module `comp_ffs`: a 32-bit find-first-set returning a 5-bit index and a found flag. It is instantiated only under `COMP_ZRL_EN`.

## Test plan
- **Dense block → SR.** 16 nonzero words, `sop_i`/`eop_i` correct → header 0x8000_0010_0000_0000, then 16 words unchanged, `eop_o` on the 17th beat, `err_o`=0.
- **Sparse block → ZRL.** 16 words, only word 0=0xA and word 5=0xB nonzero → header 0x4000_0010_0000_0021, payload 0xA, 0xB, `eop_o` on 0xB.
- **All-zero block.** 16 zero words → single beat 0x4000_0010_0000_0000 with `sop_o`=`eop_o`=1; `ready_o` returns to 1 one cycle later.
- **Backpressure.** Case 2 with `ready_i` toggling 1,0,0,1,… → data held while stalled, output sequence identical to case 2, exactly 3 beats.
- **Protocol errors.**
  - A 3-word block with `eop_i` → header count 3.
  - Then `sop_i` on word 2 of the next block → partial block discarded, `err_o` stays 1 until reset.
  - 17 words with no `eop_i` → block closes at 16, `err_o`=1.
- **Macro off.** Case 2 built without `COMP_ZRL_EN` → SR header 0x8000_0010_0000_0000 and all 16 words emitted.
